// File: rtl/ifmap_dbuf_ctrl_if.sv
// Write-stream and read-stream handshake bundle for the ifmap double buffer.
// master: the buffer controller; slave: stream source and array feeder.
interface ifmap_dbuf_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic wadr_en;
  logic radr_en;
  logic out_valid;
  logic out_ready;

  modport master (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output wadr_en,
    output radr_en,
    output out_valid
  );

  modport slave (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  wadr_en,
    input  radr_en,
    input  out_valid
  );
endinterface

// File: rtl/ifmap_dbuf_ctrl.sv
// Ifmap double-buffer sequencer: fill/run/drain bank ping-pong per layer.
// Define IFMAP_DBUF_PERF_EN to add the stall_cycles reader-wait counter.
module ifmap_dbuf_ctrl #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] cfg_wr_count,
  input  logic [COUNT_WIDTH-1:0] cfg_rd_count,
  input  logic [COUNT_WIDTH-1:0] cfg_num_tiles,
  output logic                   config_en,
  ifmap_dbuf_ctrl_if.master      dbuf,
  output logic                   wbank_sel,
  output logic                   switch_banks,
  output logic                   busy,
  output logic                   done
`ifdef IFMAP_DBUF_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam logic [COUNT_WIDTH-1:0] ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [COUNT_WIDTH-1:0] wr_cfg, rd_cfg, nt_cfg;
  logic [COUNT_WIDTH-1:0] wr_cnt, rd_cnt;
  logic [COUNT_WIDTH-1:0] tiles_written, tiles_read;
  logic                   wr_done, rd_done;
  logic                   out_valid_q;

  logic cfg_ok, accept;
  logic last_tile_wr, wr_done_eff;
  logic in_ready, rd_en, wr_acc;
  logic wr_last, rd_last;
  logic swap, run_swap;

  assign cfg_ok = (cfg_wr_count != '0)
               && (cfg_rd_count != '0)
               && (cfg_num_tiles != '0);
  assign accept = (state == S_IDLE) && start && cfg_ok;

  // Once every tile is written the writer side is finished for good.
  assign last_tile_wr = (tiles_written == nt_cfg);
  assign wr_done_eff  = wr_done || last_tile_wr;

  assign in_ready = (state == S_FILL)
                 || ((state == S_RUN) && !wr_done_eff);
  assign rd_en = ((state == S_RUN) || (state == S_DRAIN))
              && dbuf.out_ready && !rd_done;
  assign wr_acc = dbuf.in_valid && in_ready;

  assign wr_last = wr_acc && (wr_cnt == wr_cfg - ONE);
  assign rd_last = rd_en && (rd_cnt == rd_cfg - ONE);

  // Same-cycle completions count, so the swap lands one cycle later.
  assign run_swap = (state == S_RUN)
                 && (wr_done_eff || wr_last)
                 && (rd_done || rd_last);
  assign swap = ((state == S_FILL) && wr_last) || run_swap;

  assign dbuf.in_ready  = in_ready;
  assign dbuf.wadr_en   = wr_acc;
  assign dbuf.radr_en   = rd_en;
  assign dbuf.out_valid = out_valid_q;
  assign busy           = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    config_en = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_CONFIG;
      S_CONFIG: begin
        config_en = 1'b1;
        state_nx  = S_FILL;
      end
      S_FILL: begin
        if (wr_last)
          state_nx = (nt_cfg == ONE) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (run_swap && (tiles_read + ONE == nt_cfg - ONE))
          state_nx = S_DRAIN;
      end
      S_DRAIN: if (rd_last) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cfg        <= '0;
      rd_cfg        <= '0;
      nt_cfg        <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      tiles_written <= '0;
      tiles_read    <= '0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      out_valid_q   <= 1'b0;
      switch_banks  <= 1'b0;
      wbank_sel     <= 1'b0;
    end else begin
      out_valid_q  <= rd_en;
      switch_banks <= swap;
      if (accept) begin
        wr_cfg        <= cfg_wr_count;
        rd_cfg        <= cfg_rd_count;
        nt_cfg        <= cfg_num_tiles;
        wr_cnt        <= '0;
        rd_cnt        <= '0;
        tiles_written <= '0;
        tiles_read    <= '0;
        wr_done       <= 1'b0;
        rd_done       <= 1'b0;
      end
      if (wr_acc) begin
        wr_cnt <= wr_cnt + ONE;
        if (wr_last) wr_done <= 1'b1;
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + ONE;
        if (rd_last) rd_done <= 1'b1;
      end
      if (swap) begin
        wbank_sel <= ~wbank_sel;
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        wr_done   <= 1'b0;
        rd_done   <= 1'b0;
        if (state == S_FILL) begin
          tiles_written <= ONE;
        end else begin
          if (!last_tile_wr)
            tiles_written <= tiles_written + ONE;
          tiles_read <= tiles_read + ONE;
        end
      end
      if ((state == S_DRAIN) && rd_last) begin
        rd_cnt  <= '0;
        rd_done <= 1'b0;
      end
    end
  end

`ifdef IFMAP_DBUF_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept)
      stall_cycles <= '0;
    else if ((state == S_RUN) && rd_done
             && !wr_done_eff && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifmap_dbuf_ctrl.sv
// Directed bench for ifmap_dbuf_ctrl with hand-computed expectations.
// Define IFMAP_DBUF_PERF_EN to also check stall_cycles.
module tb_ifmap_dbuf_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_wr_count, cfg_rd_count, cfg_num_tiles;
  logic        config_en, wbank_sel, switch_banks, busy, done;
`ifdef IFMAP_DBUF_PERF_EN
  logic [31:0] stall_cycles;
`endif

  ifmap_dbuf_ctrl_if bus ();

  ifmap_dbuf_ctrl #(.COUNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_wr_count  (cfg_wr_count),
    .cfg_rd_count  (cfg_rd_count),
    .cfg_num_tiles (cfg_num_tiles),
    .config_en     (config_en),
    .dbuf          (bus),
    .wbank_sel     (wbank_sel),
    .switch_banks  (switch_banks),
    .busy          (busy),
    .done          (done)
`ifdef IFMAP_DBUF_PERF_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int n_cfg = 0, n_wadr = 0, n_radr = 0, n_sw = 0;
  int n_done = 0, n_busy = 0;
  int rd_bad = 0, ov_bad = 0, sw_bad = 0;
  int w_since = 0, exp_wr = 0;
  int cfg_cyc = 0, done_cyc = 0;
  logic       rv_prev = 1'b0;
  logic [7:0] wb_hist = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rv_prev = 1'b0;
      w_since = 0;
    end else begin
      n_cfg  += int'(config_en);
      n_wadr += int'(bus.wadr_en);
      n_radr += int'(bus.radr_en);
      n_sw   += int'(switch_banks);
      n_done += int'(done);
      n_busy += int'(busy);
      if (bus.radr_en && !bus.out_ready) rd_bad++;
      if (bus.wadr_en != (bus.in_valid && bus.in_ready)) rd_bad++;
      if (bus.out_valid != rv_prev) ov_bad++;
      rv_prev = bus.radr_en;
      if (switch_banks) begin
        if (w_since != exp_wr) sw_bad++;
        w_since = 0;
        wb_hist = {wb_hist[6:0], wbank_sel};
      end
      w_since += int'(bus.wadr_en);
      if (config_en) cfg_cyc = cyc;
      if (done) done_cyc = cyc;
    end
  end

  int cyc0, timeout;
  int b_cfg, b_wadr, b_radr, b_sw, b_done, b_busy;
  int b_rd_bad, b_ov_bad, b_sw_bad;

  task automatic run_layer(input int wr, input int rd, input int nt,
                           input int iv_per, input int or_tog,
                           input int stop_sw, input int max_cyc);
    exp_wr        = wr;
    cfg_wr_count  = 16'(wr);
    cfg_rd_count  = 16'(rd);
    cfg_num_tiles = 16'(nt);
    cyc0 = cyc;
    b_cfg = n_cfg; b_wadr = n_wadr; b_radr = n_radr;
    b_sw = n_sw; b_done = n_done; b_busy = n_busy;
    b_rd_bad = rd_bad; b_ov_bad = ov_bad; b_sw_bad = sw_bad;
    timeout = 1;
    for (int c = 0; c < max_cyc; c++) begin
      start = (c == 0);
      bus.in_valid  = (iv_per <= 1) ? 1'b1 : ((c % iv_per) == 2);
      bus.out_ready = (or_tog != 0) ? ((c % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      if (n_done != b_done ||
          (stop_sw > 0 && (n_sw - b_sw) >= stop_sw)) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] out_vec();
    return {23'd0, config_en, bus.in_ready, bus.wadr_en,
            bus.radr_en, bus.out_valid, wbank_sel,
            switch_banks, busy, done};
  endfunction

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_wr_count  = '0;
    cfg_rd_count  = '0;
    cfg_num_tiles = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_outputs", out_vec(), 32'd0);

    // Single tile
    run_layer(4, 6, 1, 1, 0, 0, 100);
    check("t1_timeout", timeout, 0);
    check("t1_cfg_lat", cfg_cyc - cyc0, 1);
    check("t1_cfg_cnt", n_cfg - b_cfg, 1);
    check("t1_wadr", n_wadr - b_wadr, 4);
    check("t1_radr", n_radr - b_radr, 6);
    check("t1_switch", n_sw - b_sw, 1);
    check("t1_done_lat", done_cyc - cyc0, 12);
    check("t1_wbank", wbank_sel, 1);
    check("t1_ov", ov_bad - b_ov_bad, 0);
    check("t1_sw_wr", sw_bad - b_sw_bad, 0);
    check("t1_busy_end", busy, 0);

    // Three tiles, free-flowing
    do_reset();
    run_layer(8, 5, 3, 1, 0, 0, 200);
    check("t2_timeout", timeout, 0);
    check("t2_wadr", n_wadr - b_wadr, 24);
    check("t2_radr", n_radr - b_radr, 15);
    check("t2_switch", n_sw - b_sw, 3);
    check("t2_done", n_done - b_done, 1);
    check("t2_wb_hist", wb_hist[2:0], 3'b101);
    check("t2_done_lat", done_cyc - cyc0, 31);
    check("t2_ov", ov_bad - b_ov_bad, 0);
    check("t2_sw_wr", sw_bad - b_sw_bad, 0);

    // Read backpressure
    do_reset();
    run_layer(4, 6, 2, 1, 1, 0, 200);
    check("t3_timeout", timeout, 0);
    check("t3_radr", n_radr - b_radr, 12);
    check("t3_wadr", n_wadr - b_wadr, 8);
    check("t3_switch", n_sw - b_sw, 2);
    check("t3_rd_gate", rd_bad - b_rd_bad, 0);
    check("t3_ov", ov_bad - b_ov_bad, 0);

    // Slow writer
    do_reset();
    run_layer(4, 2, 3, 4, 0, 0, 300);
    check("t4_timeout", timeout, 0);
    check("t4_wadr", n_wadr - b_wadr, 12);
    check("t4_radr", n_radr - b_radr, 6);
    check("t4_switch", n_sw - b_sw, 3);
    check("t4_sw_wr", sw_bad - b_sw_bad, 0);
    check("t4_done_lat", done_cyc - cyc0, 49);
`ifdef IFMAP_DBUF_PERF_EN
    check("t4_stall", stall_cycles, 28);
`endif

    // Zero config is ignored
    run_layer(4, 0, 1, 1, 0, 0, 10);
    check("t5_no_done", timeout, 1);
    check("t5_cfg", n_cfg - b_cfg, 0);
    check("t5_busy", n_busy - b_busy, 0);

    // Reset in tile 2, then a clean layer
    do_reset();
    run_layer(8, 5, 3, 1, 0, 2, 200);
    check("t6_reach_tile2", timeout, 0);
    check("t6_busy_pre", busy, 1);
    do_reset();
    check("t6_reset_outputs", out_vec(), 32'd0);
    b_done = n_done;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_done", n_done - b_done, 0);
    check("t6_idle", busy, 0);
    run_layer(4, 6, 1, 1, 0, 0, 100);
    check("t6_rerun", timeout, 0);
    check("t6_rerun_radr", n_radr - b_radr, 6);
    check("t6_rerun_wadr", n_wadr - b_wadr, 4);
    check("t6_rerun_wbank", wbank_sel, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ifmap_dbuf_ctrl.md
Name: ifmap_dbuf_ctrl

Overview:
- Sequences the input-feature-map double buffer for one convolution layer.
- A write stream fills one bank while the ifmap read address generator drains the other bank.
- The block pulses config_en into the address generators, gates their adr_en/wen stepping, swaps banks when both sides finish a tile, and signals layer completion.
- Sits between the DMA/input stream, the ifmap write/read address generators and the systolic array feeder.

Parameters:
- COUNT_WIDTH, 16, width of per-tile word counts and the tile counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a layer (honoured only in IDLE)
- cfg_wr_count  in  COUNT_WIDTH  words written per tile (IX0*IY0*IC1)
- cfg_rd_count  in  COUNT_WIDTH  addresses read per tile (OX0*OY0*FX*FY*IC1)
- cfg_num_tiles  in  COUNT_WIDTH  tiles in the layer
- config_en  out  1  one-cycle pulse to the address generators' config load
- in_valid  in  1  write-stream word valid
- in_ready  out  1  write-stream ready; a word transfers on in_valid&&in_ready
- wadr_en  out  1  equals in_valid&&in_ready; steps the write address generator
- radr_en  out  1  steps the read address generator (ifmap_radr_gen adr_en)
- out_valid  out  1  read data valid to the array, radr_en delayed 1 cycle
- out_ready  in  1  array can accept a read word
- wbank_sel  out  1  bank currently being written; the read bank is ~wbank_sel
- switch_banks  out  1  one-cycle pulse when banks swap
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset (rst_n low at clk edge, synchronous): state=IDLE. All outputs 0, including wbank_sel=0. All counters and flags cleared. A mid-layer reset aborts immediately; there is no done pulse.
- Config values are latched on accepted start. Inputs are ignored afterwards.
- start is ignored if any cfg value is 0; the block stays IDLE with no response.
- States:
  - IDLE: on start -> CONFIG.
  - CONFIG: config_en=1 for exactly this cycle -> FILL.
  - FILL: in_ready=1, radr_en=0. On the cfg_wr_count-th accepted word: switch_banks pulses next cycle, wbank_sel toggles, tiles_written=1.
    - If cfg_num_tiles==1 -> DRAIN, else -> RUN.
  - RUN: write and read proceed concurrently.
    - in_ready=!wr_done. wr_done is set on the cfg_wr_count-th accept.
    - In the final RUN tile (tiles_written==cfg_num_tiles), in_ready=0 and wr_done is treated as set.
    - radr_en = out_ready && !rd_done. rd_done is set on the cfg_rd_count-th issue.
    - When wr_done && rd_done: switch pulse, wbank_sel toggle, both counts and flags cleared, tiles_written++ if a write occurred, tiles_read++.
    - If tiles_read reaches cfg_num_tiles-1 after the swap -> DRAIN.
  - DRAIN: read only; in_ready=0. On the cfg_rd_count-th issue -> DONE. There is no bank switch.
  - DONE: done=1 and busy=1 for one cycle, out_valid of the last word is high this cycle -> IDLE.
- Both completion events in the same cycle count as both done; the swap is asserted the following cycle.
- The block never issues radr_en on a bank not yet fully written.
- Counters wrap at 2^COUNT_WIDTH; configs must stay below that limit.
- Latency:
  - start -> config_en: 1 cycle.
  - radr_en -> out_valid: 1 cycle, independent of out_ready.

Optional Feature:
- Macro: IFMAP_DBUF_PERF_EN.
- Defined: adds output stall_cycles [31:0]. It counts RUN cycles where rd_done && !wr_done (reader waiting on writer). Cleared on reset and on accepted start; saturates at all-ones.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single tile: wr=4, rd=6, tiles=1, in_valid and out_ready always 1.
  -> config_en at cycle 1, 4 wadr_en, one switch, 6 radr_en, done about 12 cycles after start, wbank_sel ends at 1.
- Three tiles, wr=8, rd=5, free-flowing.
  -> exactly 3 switch_banks pulses, 15 radr_en total, 24 wadr_en, wbank_sel toggles 0→1→0→1, done once.
- Backpressure: out_ready toggled 1/0 each cycle, tiles=2.
  -> radr_en only when out_ready=1, out_valid follows 1 cycle later, read counts still exact.
- Writer slow: in_valid every 4th cycle, wr=4, rd=2, tiles=3.
  -> switches occur only after wr_done.
  -> With IFMAP_DBUF_PERF_EN, stall_cycles is greater than 0 and matches the scoreboard count.
- Zero config: start with cfg_rd_count=0.
  -> stays IDLE, busy=0, no config_en.
- Reset mid-RUN: assert rst_n=0 for 1 cycle during tile 2.
  -> all outputs 0, wbank_sel=0, no done; a new start runs cleanly.
